// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control unit and the RV32I datapath.
// master = control unit, slave = datapath.
interface multicycle_control_if #(
  parameter int ALU_CTRL_WIDTH = 3
);
  logic [6:0]                op;
  logic [2:0]                funct3;
  logic                      funct7b5;
  logic                      Zero;
  logic                      PCWrite;
  logic                      AdrSrc;
  logic                      MemWrite;
  logic                      IRWrite;
  logic                      RegWrite;
  logic [1:0]                ResultSrc;
  logic [1:0]                ALUSrcA;
  logic [1:0]                ALUSrcB;
  logic [1:0]                ImmSrc;
  logic [ALU_CTRL_WIDTH-1:0] ALUControl;
  logic                      Illegal;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
    output ALUControl, Illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
    input  ALUControl, Illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM and ALU decoder for the multicycle RV32I datapath.
// Build option: RV_MC_JAL_EN adds the JAL state; otherwise jal traps.
module multicycle_control #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  multicycle_control_if.master ctl
);
  if (DATA_WIDTH != 32 || ALU_CTRL_WIDTH < 3) begin : g_param_chk
    $error("multicycle_control: unsupported parameters");
  end

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ,
`ifdef RV_MC_JAL_EN
    JAL,
`endif
    TRAP
  } state_t;

  state_t     state;
  state_t     next;
  logic       illegal_q;
  logic [1:0] aluop;
  logic [2:0] aluctl;
  logic       pcw;
  logic       irw;
  logic       memw;
  logic       regw;
  logic       adr;
  logic [1:0] res;
  logic [1:0] srca;
  logic [1:0] srcb;
  logic [1:0] imm;

  logic is_load, is_store, is_r, is_i, is_beq, is_jal;

  assign is_load  = ctl.op == 7'b0000011;
  assign is_store = ctl.op == 7'b0100011;
  assign is_r     = ctl.op == 7'b0110011;
  assign is_i     = ctl.op == 7'b0010011;
  assign is_beq   = ctl.op == 7'b1100011;
  assign is_jal   = ctl.op == 7'b1101111;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= next;
      if (next == TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    next = state;
    case (state)
      FETCH:  next = DECODE;
      DECODE: begin
        unique case (1'b1)
          is_load, is_store: next = MEMADR;
          is_r:              next = EXECUTER;
          is_i:              next = EXECUTEI;
          is_beq:            next = BEQ;
`ifdef RV_MC_JAL_EN
          is_jal:            next = JAL;
`endif
          default:           next = TRAP;
        endcase
      end
      MEMADR:   next = is_load ? MEMREAD : MEMWRITE;
      MEMREAD:  next = MEMWB;
      EXECUTER: next = ALUWB;
      EXECUTEI: next = ALUWB;
`ifdef RV_MC_JAL_EN
      JAL:      next = ALUWB;
`endif
      MEMWB:    next = FETCH;
      MEMWRITE: next = FETCH;
      ALUWB:    next = FETCH;
      BEQ:      next = FETCH;
      TRAP:     next = TRAP;
      default:  next = FETCH;
    endcase
  end

  always_comb begin
    pcw   = 1'b0;
    irw   = 1'b0;
    memw  = 1'b0;
    regw  = 1'b0;
    adr   = 1'b0;
    res   = 2'b00;
    srca  = 2'b00;
    srcb  = 2'b00;
    aluop = 2'b00;
    case (state)
      FETCH: begin
        irw  = 1'b1;
        pcw  = 1'b1;
        srcb = 2'b10;
        res  = 2'b10;
      end
      DECODE: begin
        srca = 2'b01;
        srcb = 2'b01;
      end
      MEMADR: begin
        srca = 2'b10;
        srcb = 2'b01;
      end
      MEMREAD: adr = 1'b1;
      MEMWB: begin
        res  = 2'b01;
        regw = 1'b1;
      end
      MEMWRITE: begin
        adr  = 1'b1;
        memw = 1'b1;
      end
      EXECUTER: begin
        srca  = 2'b10;
        aluop = 2'b10;
      end
      EXECUTEI: begin
        srca  = 2'b10;
        srcb  = 2'b01;
        aluop = 2'b10;
      end
      ALUWB: regw = 1'b1;
      BEQ: begin
        srca  = 2'b10;
        aluop = 2'b01;
        pcw   = ctl.Zero;
      end
`ifdef RV_MC_JAL_EN
      JAL: begin
        srca = 2'b01;
        srcb = 2'b10;
        pcw  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    imm = 2'b00;
    unique case (1'b1)
      is_load, is_i: imm = 2'b00;
      is_store:      imm = 2'b01;
      is_beq:        imm = 2'b10;
      is_jal:        imm = 2'b11;
      default:       imm = 2'b00;
    endcase
  end

  // op[5] separates R-type sub from I-type addi with imm[10] set
  always_comb begin
    aluctl = 3'b000;
    case (aluop)
      2'b00: aluctl = 3'b000;
      2'b01: aluctl = 3'b001;
      2'b10: begin
        case (ctl.funct3)
          3'b000:  aluctl = (ctl.op[5] & ctl.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  aluctl = 3'b101;
          3'b110:  aluctl = 3'b011;
          3'b111:  aluctl = 3'b010;
          default: aluctl = 3'b000;
        endcase
      end
      default: aluctl = 3'b000;
    endcase
  end

  // write enables must not glitch through while reset is held
  assign ctl.PCWrite    = pcw & rst_n;
  assign ctl.IRWrite    = irw & rst_n;
  assign ctl.MemWrite   = memw & rst_n;
  assign ctl.RegWrite   = regw & rst_n;
  assign ctl.AdrSrc     = adr;
  assign ctl.ResultSrc  = res;
  assign ctl.ALUSrcA    = srca;
  assign ctl.ALUSrcB    = srcb;
  assign ctl.ImmSrc     = imm;
  assign ctl.ALUControl = ALU_CTRL_WIDTH'(aluctl);
  assign ctl.Illegal    = illegal_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: random and directed instruction
// sequences checked cycle by cycle against an instruction-level model.
module tb_multicycle_control;
  logic clk;
  logic rst_n;

  multicycle_control_if #(.ALU_CTRL_WIDTH(3)) bus();

  multicycle_control #(
    .DATA_WIDTH(32),
    .ALU_CTRL_WIDTH(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ctl(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RV_MC_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  typedef enum int {K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_BAD} kind_t;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       ill;
  } ctl_t;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [6:0] op_of(kind_t k);
    case (k)
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_BEQ:   return 7'b1100011;
      K_JAL:   return 7'b1101111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // arithmetic op requested by funct3, with sub only for real R-type sub
  function automatic logic [2:0] arith(logic [2:0] f3, logic sub);
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit traps(kind_t k);
    return (k == K_BAD) || (k == K_JAL && !JAL_EN);
  endfunction

  function automatic int ncyc(kind_t k);
    if (traps(k)) return 12;
    if (k == K_LW) return 5;
    if (k == K_BEQ) return 3;
    return 4;
  endfunction

  function automatic ctl_t expect_at(kind_t k, int c, logic [2:0] f3,
                                     logic f7, logic z);
    ctl_t e;
    e = '0;
    e.imm = imm_of(op_of(k));
    if (c == 0) begin
      e.pcw = 1'b1; e.irw = 1'b1; e.res = 2'b10; e.sb = 2'b10;
      return e;
    end
    if (c == 1) begin
      e.sa = 2'b01; e.sb = 2'b01;
      return e;
    end
    if (traps(k)) begin
      e.ill = 1'b1;
      return e;
    end
    case (k)
      K_LW: begin
        if (c == 2) begin e.sa = 2'b10; e.sb = 2'b01; end
        else if (c == 3) e.adr = 1'b1;
        else begin e.res = 2'b01; e.regw = 1'b1; end
      end
      K_SW: begin
        if (c == 2) begin e.sa = 2'b10; e.sb = 2'b01; end
        else begin e.adr = 1'b1; e.memw = 1'b1; end
      end
      K_R: begin
        if (c == 2) begin e.sa = 2'b10; e.alu = arith(f3, f7); end
        else e.regw = 1'b1;
      end
      K_I: begin
        if (c == 2) begin
          e.sa = 2'b10; e.sb = 2'b01; e.alu = arith(f3, 1'b0);
        end else e.regw = 1'b1;
      end
      K_BEQ: begin
        e.sa = 2'b10; e.alu = 3'b001; e.pcw = z;
      end
      K_JAL: begin
        if (c == 2) begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
        else e.regw = 1'b1;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic ctl_t reset_view(logic [6:0] o);
    ctl_t e;
    e = '0;
    e.res = 2'b10;
    e.sb  = 2'b10;
    e.imm = imm_of(o);
    return e;
  endfunction

  function automatic ctl_t sample();
    ctl_t o;
    o.pcw  = bus.PCWrite;
    o.adr  = bus.AdrSrc;
    o.memw = bus.MemWrite;
    o.irw  = bus.IRWrite;
    o.regw = bus.RegWrite;
    o.res  = bus.ResultSrc;
    o.sa   = bus.ALUSrcA;
    o.sb   = bus.ALUSrcB;
    o.imm  = bus.ImmSrc;
    o.alu  = bus.ALUControl;
    o.ill  = bus.Illegal;
    return o;
  endfunction

  task automatic chk(input string tag, input ctl_t e);
    ctl_t o;
    o = sample();
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // entered just after the edge that starts FETCH; leaves just after
  // the edge that ends cycle ncut-1
  task automatic run(input kind_t k, input logic [2:0] f3, input logic f7,
                     input int zm, input int ncut);
    int n;
    n = (ncut > 0) ? ncut : ncyc(k);
    bus.op       = op_of(k);
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    for (int c = 0; c < n; c++) begin
      bus.Zero = (zm < 0) ? 1'($urandom_range(0, 1)) : zm[0];
      @(negedge clk);
      chk($sformatf("%s c%0d f3=%0d f7=%0d z=%0d", k.name(), c, f3, f7,
                    bus.Zero), expect_at(k, c, f3, f7, bus.Zero));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, " rst"}, reset_view(bus.op));
    @(posedge clk);
    #1;
    chk({tag, " rst hold"}, reset_view(bus.op));
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    kind_t k;
    int    nk;
    rst_n        = 1'b0;
    bus.op       = op_of(K_LW);
    bus.funct3   = 3'b000;
    bus.funct7b5 = 1'b0;
    bus.Zero     = 1'b0;
    #1;
    chk("por", reset_view(bus.op));
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("por hold", reset_view(bus.op));
    rst_n = 1'b1;

    run(K_LW, 3'b010, 1'b0, -1, 0);
    run(K_R, 3'b000, 1'b1, -1, 0);
    run(K_R, 3'b000, 1'b0, -1, 0);
    run(K_R, 3'b010, 1'b0, -1, 0);
    run(K_R, 3'b110, 1'b1, -1, 0);
    run(K_R, 3'b111, 1'b0, -1, 0);
    run(K_R, 3'b001, 1'b1, -1, 0);
    run(K_I, 3'b000, 1'b1, -1, 0);
    run(K_I, 3'b111, 1'b1, -1, 0);
    run(K_SW, 3'b010, 1'b0, -1, 0);
    run(K_BEQ, 3'b000, 1'b0, 1, 0);
    run(K_BEQ, 3'b000, 1'b0, 0, 0);
    run(K_LW, 3'b010, 1'b0, -1, 0);

    nk = JAL_EN ? 5 : 4;
    for (int i = 0; i < 60; i++) begin
      k = kind_t'($urandom_range(0, nk));
      run(k, 3'($urandom), 1'($urandom), -1, 0);
    end

    run(K_BAD, 3'b000, 1'b0, -1, 0);
    do_reset("trap");
    run(K_LW, 3'b000, 1'b0, -1, 0);

    run(K_SW, 3'b010, 1'b0, -1, 3);
    chk("memwrite live", expect_at(K_SW, 3, 3'b010, 1'b0, 1'b0));
    do_reset("abort sw");
    run(K_R, 3'b000, 1'b1, -1, 0);

    run(K_JAL, 3'b000, 1'b0, -1, 0);
    if (!JAL_EN) do_reset("jal trap");
    run(K_BEQ, 3'b000, 1'b0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle RV32I datapath. It is a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath mux selects and write enables. It also contains the ALU decoder that produces the 3-bit `ALUControl` code the ALU consumes. The ALU's `Zero` flag (operand equality) feeds back into this block to resolve `beq`.

## Interface
- `DATA_WIDTH`, 32: datapath width. Used only for documentation and assertions.
- `ALU_CTRL_WIDTH`, 3: width of `ALUControl`.
- `clk` input 1: single clock. All state changes happen on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `op` input 7: `Instr[6:0]` from the instruction register.
- `funct3` input 3: `Instr[14:12]`.
- `funct7b5` input 1: `Instr[30]`.
- `Zero` input 1: ALU equality flag.
- `PCWrite` output 1: PC register enable.
- `AdrSrc` output 1: memory address select. 0 = PC, 1 = Result.
- `MemWrite` output 1: data memory write enable.
- `IRWrite` output 1: instruction register and OldPC enable.
- `RegWrite` output 1: register file write enable.
- `ResultSrc` output 2: result select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` output 2: ALU operand A select. 00 = PC, 01 = OldPC, 10 = A (rs1).
- `ALUSrcB` output 2: ALU operand B select. 00 = WriteData (rs2), 01 = ImmExt, 10 = constant 4.
- `ImmSrc` output 2: immediate format. 00 = I, 01 = S, 10 = B, 11 = J.
- `ALUControl` output 3: ALU operation. 000 = add, 001 = sub, 101 = slt, 011 = or, 010 = and.
- `Illegal` output 1: sticky flag; the unsupported-opcode trap has been taken.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP.
- Transitions:
  - FETCH→DECODE always.
  - From DECODE by `op`:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1100011 → BEQ.
    - 1101111 → JAL.
    - anything else → TRAP.
  - MEMADR → MEMREAD if `op` = 0000011, else MEMWRITE.
  - MEMREAD → MEMWB.
  - EXECUTER, EXECUTEI and JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ → FETCH.
  - TRAP holds until reset.
- Per-state outputs. Any output not listed is 0 and ALUOp is 00.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCWrite=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch/jump target).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=`Zero`.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
- `ImmSrc` is decoded from `op` alone, independent of state:
  - I (0000011, 0010011) → 00.
  - S (0100011) → 01.
  - B (1100011) → 10.
  - J (1101111) → 11.
  - Otherwise → 00.
- ALU decoder (combinational):
  - ALUOp 00 → 000.
  - ALUOp 01 → 001.
  - ALUOp 10, by `funct3`:
    - 000 → 001 if `op[5]` & `funct7b5`, else 000.
    - 010 → 101.
    - 110 → 011.
    - 111 → 010.
    - Any other `funct3` → 000 (unsupported; no trap).
- `Illegal` sets on entry to TRAP. It clears only on reset.

## Timing
- Reset (asynchronous assert, synchronous-edge release): state=FETCH, `Illegal`=0.
- While `rst_n`=0, `PCWrite`, `IRWrite`, `MemWrite` and `RegWrite` are forced to 0 combinationally. Other outputs show FETCH values.
- The first active edge after `rst_n` rises executes FETCH.
- Outputs are combinational from the state register, `op`/`funct` and `Zero`. There is no output register. Sample-side registers capture on the edge ending the state.
- Cycles per instruction:
  - lw 5.
  - sw, R-type, I-type ALU, jal 4.
  - beq 3.
- `Zero` is used only in BEQ, combinationally, in the same cycle.
- Reset asserted mid-instruction aborts it immediately. No partial writes occur after the assertion.
- `op` is stable from DECODE until FETCH, because IRWrite is asserted only in FETCH.

## Configuration
- `RV_MC_JAL_EN` defined: JAL state present; `op` 1101111 executes jal (rd←PC+4, PC←target) in 4 cycles.
- `RV_MC_JAL_EN` undefined: no JAL state; 1101111 decodes to TRAP and sets `Illegal`.
- `ImmSrc` 11 is still driven for J-format in both builds.

## Test plan
- Reset then release, op=0000011 loaded in FETCH:
  - Cycles 1–5 visit FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - RegWrite=1 only in cycle 5, ResultSrc=01.
- R-type op=0110011, funct3=000, funct7b5=1:
  - EXECUTER shows ALUControl=001.
  - Same with funct7b5=0 shows 000.
  - funct3=010/110/111 shows 101/011/010.
- I-type op=0010011, funct3=000, funct7b5=1 (immediate bit): ALUControl=000, not sub.
- beq with Zero=1 in BEQ: PCWrite=1 and the next state is FETCH. With Zero=0: PCWrite=0. The instruction takes 3 cycles either way.
- op=1111111: DECODE→TRAP, Illegal=1, all enables 0 for 10+ cycles. Pulsing rst_n low clears Illegal and returns to FETCH.
- Reset asserted during MEMWRITE: MemWrite drops to 0 in the same cycle. The state is FETCH after release.
- jal op=1101111 with the macro defined: 4 cycles, PCWrite=1 in JAL. Without the macro: TRAP.
